// File: rtl/proc_io_fifo_if.sv
// Processor external-bus and consumer-stream signals seen by proc_io_fifo.
// slave is the peripheral's view; master is the processor/memory/consumer side.
interface proc_io_fifo_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] MEM_Q;
    logic        MEM_WE;
    logic [15:0] DIN;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  ADDR, DOUT, W, MEM_Q, out_ready,
        output MEM_WE, DIN, out_data, out_valid
    );

    modport master (
        output ADDR, DOUT, W, MEM_Q, out_ready,
        input  MEM_WE, DIN, out_data, out_valid
    );
endinterface

// File: rtl/proc_io_fifo.sv
// Memory-mapped output FIFO: stores to the window push words, a valid/ready
// consumer drains them, loads from the window return status through DIN.
module proc_io_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter logic [3:0]  BASE  = 4'h1
) (
    input  logic            Clock,
    input  logic            Reset,
    proc_io_fifo_if.slave   bus
);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    ovf;
    logic          sel_q;
    logic [15:0]   rdata_q;

    logic          hit;
    logic [1:0]    offset;
    logic          push_req;
    logic          flush_req;
    logic          ovf_clr;
    logic          pop;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          push_drop;
    logic [15:0]   reg_val;
    logic          unused_addr;

    assign unused_addr = ^bus.ADDR[11:2];

    always_comb begin
        hit       = (bus.ADDR[15:12] == BASE);
        offset    = bus.ADDR[1:0];
        full      = (count == (AW+1)'(DEPTH));
        empty     = (count == '0);
        push_req  = bus.W & hit & (offset == 2'd0);
        flush_req = bus.W & hit & (offset == 2'd2);
        ovf_clr   = bus.W & hit & (offset == 2'd3);
        pop       = ~empty & bus.out_ready;
        // A pop frees the slot the same edge, so a full FIFO still accepts.
        push_ok   = push_req & (~full | pop);
        push_drop = push_req & ~push_ok;
    end

    always_comb begin
        reg_val = '0;
        case (offset)
            2'd1:    reg_val[AW+3:0] = {count, |ovf, full, empty};
            2'd3:    reg_val[7:0]    = ovf;
            default: reg_val         = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.DOUT;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_req) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf <= '0;
        end else if (ovf_clr) begin
            ovf <= '0;
        end else if (push_drop && ovf != 8'hFF) begin
            ovf <= ovf + 8'd1;
        end
    end

    // Registered read data lines up with the memory's one-cycle latency.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sel_q   <= hit;
            rdata_q <= reg_val;
        end
    end

    assign bus.MEM_WE    = bus.W & ~hit;
    assign bus.DIN       = sel_q ? rdata_q : bus.MEM_Q;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_valid = ~empty;

endmodule

// File: doc/proc_io_fifo.md
# proc_io_fifo

Memory-mapped output-FIFO peripheral on the processor's external bus, between the processor's ADDR/DOUT/W outputs and its DIN input. Stores in writes to its address window push 16-bit words into a DEPTH-entry FIFO, which a downstream consumer drains over a valid/ready handshake. Loads from the window return status; loads elsewhere pass the synchronous memory's read data through to DIN.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- AW, 3: log2(DEPTH).
- BASE, 4'h1: window select, compared against ADDR[15:12].

Ports (clock and reset first):
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ADDR  in  16  processor address register output.
- DOUT  in  16  processor write data.
- W  in  1  processor write strobe; high for exactly one cycle per store, with ADDR and DOUT valid in that cycle.
- MEM_Q  in  16  synchronous memory read data; one-cycle latency from ADDR.
- MEM_WE  out  1  memory write enable, equal to W & ~hit. Combinational.
- DIN  out  16  read data to the processor.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.

## Operation
- hit = (ADDR[15:12] == BASE). Register offset is ADDR[1:0]; ADDR[11:2] is ignored, so registers alias across the window.
- Register map:
  - Offset 0, write: push DOUT. Offset 0, read: returns 16'h0000.
  - Offset 1, read (status): {zero-pad, count[AW:0], overflow_nz, full, empty} in bits [AW+3:0]. Writes are ignored.
  - Offset 2, write: flush. Sets count to 0 and resets both pointers; stored data is not cleared. Offset 2, read: returns 16'h0000.
  - Offset 3, read: {8'h00, ovf[7:0]}. Offset 3, write: sets ovf to 0.
- FIFO storage:
  - Register array indexed by wr_ptr and rd_ptr, each AW bits, wrapping modulo DEPTH.
  - count is AW+1 bits, 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- push_req = W & hit & (offset == 0).
- pop = out_valid & out_ready.
- A push is accepted when ~full | pop. When full and popping in the same cycle, both happen and count stays DEPTH.
- A rejected push drops the word. ovf increments, saturating at 8'hFF.
- Simultaneous events:
  - Flush in the same cycle as a pop: flush wins, and the pop is discarded.
  - Flush and push cannot coincide (different offsets).
  - Overflow increment in the same cycle as an ovf-clear write cannot coincide (single W).
- out_data = storage[rd_ptr] and out_valid = ~empty. Both are valid in the cycle after the accepting edge.
- Read path:
  - At every edge: sel_q <= hit; rdata_q <= register value selected by offset.
  - DIN = sel_q ? rdata_q : MEM_Q.
  - This matches the memory's one-cycle latency, so the processor's wait cycle covers both sources.
- Reset (asynchronous):
  - count, wr_ptr, rd_ptr, ovf, sel_q and rdata_q go to 0.
  - out_valid = 0, DIN = MEM_Q, MEM_WE follows W.
  - Storage contents are unspecified.
  - Reset during a store discards that store.

## Timing
- Push latency: W in cycle N, then out_valid = 1 and out_data valid in cycle N+1.
- Pop: handshake at edge E, then the next head or out_valid = 0 from E onward.
- Status read: ADDR presented in cycle N, then DIN valid in cycle N+1. The value reflects state at the end of cycle N, so a push in cycle N-1 is visible.
- out_data is stable while out_valid & ~out_ready. A push into a non-empty FIFO never changes out_data.
- No combinational path from out_ready to out_valid or out_data.
- MEM_WE is combinational from W and ADDR. DIN is combinational from MEM_Q only through the sel_q mux.

## Test plan
- Reset, then DEPTH stores of 16'h1000+i to 0x1000 with out_ready=0:
  - out_valid=1; status read shows count=8, full=1, empty=0.
  - MEM_WE stays 0 throughout.
- Ninth store 16'hBEEF while full:
  - Word dropped; offset 3 reads 16'h0001.
  - Drain with out_ready=1 yields 16'h1000..16'h1007, then out_valid=0.
- Full FIFO with out_ready=1 and a same-cycle push of 16'h00AA:
  - Accepted, count stays 8, ovf unchanged.
  - 16'h00AA emerges last.
- 300 stores into a full FIFO:
  - ovf saturates at 8'hFF.
  - Write to 0x1003 reads back 16'h0000.
- Three pushes, then a flush write to 0x1002 together with out_ready=1:
  - out_valid=0 next cycle; status empty=1.
  - A subsequent push of 16'h0055 appears as out_data.
- Load from 0x0004 with MEM_Q=16'h1234 one cycle later:
  - DIN=16'h1234; a store to 0x0004 asserts MEM_WE.
  - Assert Reset mid-stream: out_valid drops immediately and asynchronously.
